// File: rtl/wide_add_sequencer_if.sv
// Start/busy/done handshake and wide operand/result bus between a control FSM
// and the multi-precision adder sequencer.
interface wide_add_sequencer_if #(
    parameter int NUM_WORDS = 4
);
    localparam int W = 16 * NUM_WORDS;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    modport master (
        output start, op_a, op_b, carry_in,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op_a, op_b, carry_in,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: one shared 16-bit ripple adder walks the operands
// LSW first, feeding each word's carry into the next.
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);
    logic [16:0] carry;

    assign carry[0] = carry_in;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign overflow = carry[16];
endmodule

module wide_add_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    wide_add_sequencer_if.slave  bus
);
    localparam int W     = 16 * NUM_WORDS;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     a_reg, b_reg, result_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg, carry_out_reg, busy_reg, done_reg;
    logic             accept, last_word;
    logic [15:0]      a_words [NUM_WORDS];
    logic [15:0]      b_words [NUM_WORDS];
    logic [15:0]      sum_word;
    logic             overflow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            assign a_words[gi] = a_reg[16*gi +: 16];
            assign b_words[gi] = b_reg[16*gi +: 16];
        end
    endgenerate

    adder_16bit u_adder (
        .a        (a_words[idx_reg]),
        .b        (b_words[idx_reg]),
        .carry_in (carry_reg),
        .sum      (sum_word),
        .overflow (overflow)
    );

    assign last_word = (idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start in the done cycle chains straight into the next add.
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            result_reg    <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ADD);
            done_reg  <= (state_next == DONE);
            if (accept) begin
                a_reg     <= bus.op_a;
                b_reg     <= bus.op_b;
                carry_reg <= bus.carry_in;
                idx_reg   <= '0;
            end else if (state_reg == ADD) begin
                carry_reg <= overflow;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        result_reg[16*i +: 16] <= sum_word;
                    end
                end
                if (last_word) begin
                    carry_out_reg <= overflow;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: driver pushes expected sums,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_wide_add_sequencer;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic clk = 1'b0;
    logic n_rst;

    wide_add_sequencer_if #(.NUM_WORDS(NW)) bus ();

    wide_add_sequencer #(.NUM_WORDS(NW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   prev_done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) begin
            case ($urandom_range(0, 3))
                0:       v[16*i +: 16] = 16'hFFFF;
                1:       v[16*i +: 16] = 16'h0000;
                default: v[16*i +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Reference: plain unsigned W+1-bit addition.
    task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t         e;
        logic [W:0]   full;
        full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.a       = a;
        e.b       = b;
        e.cin     = cin;
        e.sum     = full[W-1:0];
        e.cout    = full[W];
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic drive_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.start    = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.carry_in = cin;
        push_expect(a, b, cin);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.op_a     = rand_op();
        bus.op_b     = rand_op();
        bus.carry_in = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        drive_now(a, b, cin);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (bus.done === 1'b1) return;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL %s_timeout: got no done within 16 cycles, expected one done pulse", tag);
    endtask

    // Entered on the first ADD cycle; leaves on the done cycle.
    task automatic check_busy_run(input string tag);
        for (int i = 0; i < NW; i++) begin
            check({tag, "_busy"}, {{W{1'b0}}, bus.busy}, 1);
            check({tag, "_done_low"}, {{W{1'b0}}, bus.done}, 0);
            @(negedge clk);
        end
        check({tag, "_busy_end"}, {{W{1'b0}}, bus.busy}, 0);
        check({tag, "_done"}, {{W{1'b0}}, bus.done}, 1);
    endtask

    always @(negedge clk) begin
        if (n_rst === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("txn a=%h b=%h cin=%0d -> result=%h cout=%0d", mon_e.a, mon_e.b, mon_e.cin,
                         bus.result, bus.carry_out);
                check("result", {1'b0, bus.result}, {1'b0, mon_e.sum});
                check("carry_out", {{W{1'b0}}, bus.carry_out}, {{W{1'b0}}, mon_e.cout});
                check("latency", (W+1)'(cyc - mon_e.acc_cyc), (W+1)'(NW));
            end
        end
    end

    always @(posedge clk) begin
        if (n_rst === 1'b1 && bus.busy === 1'b0) begin
            assert (!$isunknown(bus.start)) else $error("X on start at an accepting edge");
            if (bus.start === 1'b1) begin
                assert (!$isunknown({bus.op_a, bus.op_b, bus.carry_in}))
                    else $error("X on operands at an accepting edge");
            end
        end
    end

    initial begin
        n_rst        = 1'b0;
        bus.start    = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {{W{1'b0}}, bus.busy}, 0);
        check("rst_done", {{W{1'b0}}, bus.done}, 0);
        check("rst_result", {1'b0, bus.result}, 0);
        check("rst_carry_out", {{W{1'b0}}, bus.carry_out}, 0);
        n_rst = 1'b1;

        // Carry across a word boundary.
        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        check_busy_run("t1");
        check("t1_result_const", {1'b0, bus.result}, 65'h0_0000_0000_0001_0000);

        // Carry ripples through every word into carry_out.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_done("t2");
        check("t2_result_const", {1'b0, bus.result}, 65'h0);
        check("t2_cout_const", {{W{1'b0}}, bus.carry_out}, 1);

        // Mixed words.
        issue(64'h1234_8000_FFFF_0001, 64'h0001_8000_0001_FFFF, 1'b0);
        wait_done("t3");
        check("t3_result_const", {1'b0, bus.result}, 65'h0_1236_0001_0001_0000);

        // start held high and operands scrambled during ADD.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_a     = 64'h0123_4567_89AB_CDEF;
        bus.op_b     = 64'hFEDC_BA98_7654_3210;
        bus.carry_in = 1'b1;
        push_expect(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            bus.op_a     = rand_op();
            bus.op_b     = rand_op();
            bus.carry_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("t4_done", {{W{1'b0}}, bus.done}, 1);
        bus.start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("t4_single_done", {{W{1'b0}}, bus.done}, 0);
        end

        // Back-to-back: new start during the done cycle.
        issue(rand_op(), rand_op(), 1'b1);
        wait_done("t5a");
        prev_done_cyc = cyc;
        drive_now(64'h1, 64'h1, 1'b0);
        check("t5_no_idle_busy", {{W{1'b0}}, bus.busy}, 1);
        wait_done("t5b");
        check("t5_done_spacing", (W+1)'(cyc - prev_done_cyc), (W+1)'(NW + 1));
        check("t5_result_const", {1'b0, bus.result}, 65'h2);

        // Reset in the second ADD cycle discards the operation.
        issue(rand_op(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(negedge clk);
        n_rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("t6_busy", {{W{1'b0}}, bus.busy}, 0);
        check("t6_done", {{W{1'b0}}, bus.done}, 0);
        check("t6_result", {1'b0, bus.result}, 0);
        check("t6_carry_out", {{W{1'b0}}, bus.carry_out}, 0);
        n_rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("t6_no_done", {{W{1'b0}}, bus.done}, 0);
        end
        issue(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0);
        check_busy_run("t6_fresh");

        // Randomized operations with random back-to-back chaining.
        for (int n = 0; n < 40; n++) begin
            issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            wait_done("rand");
            if ($urandom_range(0, 1) == 1) begin
                drive_now(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
                wait_done("rand_b2b");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", (W+1)'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
